// File: rtl/reg_file.sv
// reg_file: eight-entry 8-bit general-purpose register file with a small
// LIFO save stack. Two combinational read ports plus a dedicated r0 tap.
// The stack lets the control unit push a register (addressed by read
// port A) and later pop the top entry into any register. Occupancy is
// decoded from the count register, and a sticky fault flag latches any
// overflow or underflow.

module reg_file #(
   parameter  int NUM_REGS    = 8,
   parameter  int STACK_DEPTH = 4,
   localparam int AW          = $clog2(NUM_REGS),
   localparam int IW          = $clog2(STACK_DEPTH),
   localparam int CW          = $clog2(STACK_DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [7:0]    rf_in,
   input  logic          rf_write_en,
   input  logic [AW-1:0] rf_write_addr,
   input  logic [AW-1:0] rf_read_addr_a,
   input  logic [AW-1:0] rf_read_addr_b,
   output logic [7:0]    rf_read_a,
   output logic [7:0]    rf_read_b,
   output logic [7:0]    r0,
   input  logic          push,
   input  logic          pop,
   output logic [CW-1:0] stack_count,
   output logic          stack_full,
   output logic          stack_empty,
   output logic          stack_fault,
   input  logic          fault_clear
);

   logic [NUM_REGS-1:0][7:0]    regs;
   logic [STACK_DEPTH-1:0][7:0] stk;
   logic [CW-1:0]               cnt;
   logic                        fault_q;

   logic          full, empty;
   logic          pop_ok, push_ok, ovf, udf;
   logic [IW-1:0] top_idx, push_idx;
   logic [7:0]    push_src;

   // Occupancy decode comes only from the count register.
   assign full  = (cnt == CW'(STACK_DEPTH));
   assign empty = (cnt == '0);

   // A pop frees the top slot first, so a push alongside a valid pop is
   // always accepted, even on a full stack (it replaces the top entry).
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign ovf     = push && full && !pop_ok;
   assign udf     = pop && empty;

   assign top_idx  = IW'(cnt - CW'(1));
   assign push_idx = pop_ok ? top_idx : cnt[IW-1:0];
   assign push_src = regs[rf_read_addr_a];

   // No write-through bypass: reads always see stored state.
   assign rf_read_a   = regs[rf_read_addr_a];
   assign rf_read_b   = regs[rf_read_addr_b];
   assign r0          = regs[0];
   assign stack_count = cnt;
   assign stack_full  = full;
   assign stack_empty = empty;
   assign stack_fault = fault_q;

   // Register array update: a valid pop beats rf_in; an underflowing pop
   // suppresses the write entirely.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs <= '0;
      end else if (pop_ok) begin
         regs[rf_write_addr] <= stk[top_idx];
      end else if (rf_write_en && !udf) begin
         regs[rf_write_addr] <= rf_in;
      end
   end

   // Stack storage and occupancy count; push+pop leaves the count alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stk <= '0;
         cnt <= '0;
      end else begin
         if (push_ok)
            stk[push_idx] <= push_src;
         if (push_ok && !pop_ok)
            cnt <= cnt + CW'(1);
         else if (pop_ok && !push_ok)
            cnt <= cnt - CW'(1);
      end
   end

   // Sticky fault flag: a new fault outranks a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         fault_q <= 1'b0;
      else if (ovf || udf)
         fault_q <= 1'b1;
      else if (fault_clear)
         fault_q <= 1'b0;
   end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus a randomized
// run against a queue-based behavioural model of the register file/stack.

module tb_reg_file;

   localparam int NR = 8;
   localparam int SD = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rf_in = '0;
   logic       rf_write_en = 1'b0;
   logic [2:0] rf_write_addr = '0;
   logic [2:0] rf_read_addr_a = '0;
   logic [2:0] rf_read_addr_b = '0;
   logic [7:0] rf_read_a, rf_read_b, r0;
   logic       push = 1'b0, pop = 1'b0, fault_clear = 1'b0;
   logic [2:0] stack_count;
   logic       stack_full, stack_empty, stack_fault;

   int tests = 0;
   int fails = 0;

   // Behavioural model
   logic [7:0] m_regs [NR];
   logic [7:0] m_stk [$];
   bit         m_fault;

   reg_file #(.NUM_REGS(NR), .STACK_DEPTH(SD)) dut (
      .clk(clk), .rst_n(rst_n),
      .rf_in(rf_in), .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr),
      .rf_read_addr_a(rf_read_addr_a), .rf_read_addr_b(rf_read_addr_b),
      .rf_read_a(rf_read_a), .rf_read_b(rf_read_b), .r0(r0),
      .push(push), .pop(pop),
      .stack_count(stack_count), .stack_full(stack_full),
      .stack_empty(stack_empty), .stack_fault(stack_fault),
      .fault_clear(fault_clear)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic void model_reset();
      foreach (m_regs[i]) m_regs[i] = 8'h00;
      m_stk.delete();
      m_fault = 1'b0;
   endfunction

   // One clock worth of behaviour, evaluated from the currently driven inputs.
   function automatic void model_step();
      logic [7:0] src, top;
      bit nf;
      nf  = 1'b0;
      src = m_regs[rf_read_addr_a];
      if (pop && m_stk.size() > 0) begin
         top = m_stk.pop_back();
         if (push) m_stk.push_back(src);
         m_regs[rf_write_addr] = top;
      end else if (pop) begin
         nf = 1'b1;
         if (push) m_stk.push_back(src);
      end else begin
         if (push) begin
            if (m_stk.size() == SD) nf = 1'b1;
            else m_stk.push_back(src);
         end
         if (rf_write_en) m_regs[rf_write_addr] = rf_in;
      end
      if (nf) m_fault = 1'b1;
      else if (fault_clear) m_fault = 1'b0;
   endfunction

   task automatic set_ops(input bit we, input logic [2:0] wa, input logic [7:0] d,
                          input logic [2:0] a, input logic [2:0] b,
                          input bit ps, input bit pp, input bit fc);
      rf_write_en = we; rf_write_addr = wa; rf_in = d;
      rf_read_addr_a = a; rf_read_addr_b = b;
      push = ps; pop = pp; fault_clear = fc;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      set_ops(0, 0, 0, 3'd5, 3'd2, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      tests++; if (rf_read_a !== 8'h00) begin fails++; $display("FAIL reset_read_a got %h exp 00", rf_read_a); end
      tests++; if (rf_read_b !== 8'h00) begin fails++; $display("FAIL reset_read_b got %h exp 00", rf_read_b); end
      tests++; if (r0 !== 8'h00) begin fails++; $display("FAIL reset_r0 got %h exp 00", r0); end
      tests++; if (stack_count !== 3'd0 || stack_empty !== 1'b1 || stack_full !== 1'b0 || stack_fault !== 1'b0) begin
         fails++; $display("FAIL reset_stack got cnt=%0d e=%b f=%b flt=%b exp 0 1 0 0",
                           stack_count, stack_empty, stack_full, stack_fault);
      end
      rst_n = 1'b1;
      // mid-cycle asynchronous reset
      set_ops(1, 3'd3, 8'h5A, 3'd3, 3'd0, 0, 0, 0);
      tick();
      set_ops(0, 0, 0, 3'd3, 3'd0, 0, 0, 0);
      tests++; if (rf_read_a !== 8'h5A) begin fails++; $display("FAIL pre_async_r3 got %h exp 5a", rf_read_a); end
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      tests++; if (rf_read_a !== 8'h00) begin fails++; $display("FAIL async_reset_r3 got %h exp 00", rf_read_a); end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_write_read();
      set_ops(1, 3'd0, 8'hA5, 3'd0, 3'd0, 0, 0, 0);
      tick();
      tests++; if (r0 !== 8'hA5) begin fails++; $display("FAIL write_r0 got %h exp a5", r0); end
      set_ops(1, 3'd7, 8'h3C, 3'd7, 3'd0, 0, 0, 0);
      #1;
      tests++; if (rf_read_a !== 8'h00) begin fails++; $display("FAIL no_bypass_r7 got %h exp 00", rf_read_a); end
      tick();
      tests++; if (rf_read_a !== 8'h3C) begin fails++; $display("FAIL write_r7 got %h exp 3c", rf_read_a); end
      tests++; if (rf_read_b !== 8'hA5) begin fails++; $display("FAIL read_b_r0 got %h exp a5", rf_read_b); end
   endtask

   task automatic fill_stack();
      for (int i = 1; i <= 4; i++) begin
         set_ops(0, 0, 0, 3'(i), 0, 1, 0, 0);
         tick();
      end
   endtask

   task automatic test_push_pop();
      logic [7:0] exp_v [4];
      exp_v = '{8'h44, 8'h33, 8'h22, 8'h11};
      for (int i = 1; i <= 4; i++) begin
         set_ops(1, 3'(i), 8'(i * 8'h11), 0, 0, 0, 0, 0);
         tick();
      end
      fill_stack();
      tests++; if (stack_full !== 1'b1 || stack_count !== 3'd4) begin
         fails++; $display("FAIL fill got cnt=%0d full=%b exp 4 1", stack_count, stack_full);
      end
      for (int i = 0; i < 4; i++) begin
         set_ops(0, 3'd5, 0, 3'd5, 0, 0, 1, 0);
         tick();
         tests++; if (rf_read_a !== exp_v[i]) begin
            fails++; $display("FAIL pop_%0d got %h exp %h", i, rf_read_a, exp_v[i]);
         end
      end
      set_ops(0, 0, 0, 0, 0, 0, 0, 0);
      tests++; if (stack_empty !== 1'b1 || stack_count !== 3'd0) begin
         fails++; $display("FAIL drain got cnt=%0d empty=%b exp 0 1", stack_count, stack_empty);
      end
   endtask

   task automatic test_over_under();
      fill_stack();
      set_ops(0, 0, 0, 3'd1, 0, 1, 0, 0);
      tick();
      tests++; if (stack_count !== 3'd4 || stack_fault !== 1'b1) begin
         fails++; $display("FAIL overflow got cnt=%0d flt=%b exp 4 1", stack_count, stack_fault);
      end
      set_ops(0, 0, 0, 0, 0, 0, 0, 1);
      tick();
      tests++; if (stack_fault !== 1'b0) begin fails++; $display("FAIL fault_clear got %b exp 0", stack_fault); end
      for (int i = 0; i < 4; i++) begin
         set_ops(0, 3'd6, 0, 0, 0, 0, 1, 0);
         tick();
      end
      set_ops(1, 3'd2, 8'hFF, 3'd2, 0, 0, 1, 0);
      tick();
      tests++; if (rf_read_a !== 8'h22 || stack_fault !== 1'b1 || stack_count !== 3'd0) begin
         fails++; $display("FAIL underflow got r2=%h flt=%b cnt=%0d exp 22 1 0", rf_read_a, stack_fault, stack_count);
      end
      set_ops(0, 0, 0, 0, 0, 0, 0, 1);
      tick();
      set_ops(0, 3'd2, 0, 3'd2, 0, 0, 1, 1);
      tick();
      tests++; if (stack_fault !== 1'b1) begin fails++; $display("FAIL fault_beats_clear got %b exp 1", stack_fault); end
      set_ops(0, 0, 0, 0, 0, 0, 0, 1);
      tick();
   endtask

   task automatic test_simultaneous();
      fill_stack();
      set_ops(0, 3'd6, 0, 3'd1, 3'd6, 1, 1, 0);
      tick();
      tests++; if (rf_read_b !== 8'h44 || stack_count !== 3'd4 || stack_fault !== 1'b0) begin
         fails++; $display("FAIL push_pop_full got r6=%h cnt=%0d flt=%b exp 44 4 0", rf_read_b, stack_count, stack_fault);
      end
      set_ops(0, 3'd6, 0, 0, 3'd6, 0, 1, 0);
      tick();
      tests++; if (rf_read_b !== 8'h11) begin fails++; $display("FAIL new_top got %h exp 11", rf_read_b); end
      set_ops(1, 3'd5, 8'hEE, 0, 3'd5, 0, 1, 0);
      tick();
      tests++; if (rf_read_b !== 8'h33) begin fails++; $display("FAIL pop_beats_write got %h exp 33", rf_read_b); end
      for (int i = 0; i < 2; i++) begin
         set_ops(0, 3'd7, 0, 0, 0, 0, 1, 0);
         tick();
      end
      set_ops(0, 3'd4, 0, 3'd3, 3'd4, 1, 1, 0);
      tick();
      tests++; if (stack_count !== 3'd1 || stack_fault !== 1'b1 || rf_read_b !== 8'h44) begin
         fails++; $display("FAIL push_pop_empty got cnt=%0d flt=%b r4=%h exp 1 1 44", stack_count, stack_fault, rf_read_b);
      end
   endtask

   task automatic test_random();
      int errs;
      errs = 0;
      for (int n = 0; n < 400; n++) begin
         set_ops($urandom_range(0, 1), 3'($urandom), 8'($urandom), 3'($urandom), 3'($urandom),
                 $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 10);
         tick();
         tests++;
         if (rf_read_a !== m_regs[rf_read_addr_a] || rf_read_b !== m_regs[rf_read_addr_b] ||
             r0 !== m_regs[0] || stack_count !== 3'(m_stk.size()) ||
             stack_full !== (m_stk.size() == SD) || stack_empty !== (m_stk.size() == 0) ||
             stack_fault !== m_fault) begin
            fails++;
            if (errs++ < 10)
               $display("FAIL random_%0d got a=%h b=%h r0=%h cnt=%0d f=%b e=%b flt=%b exp a=%h b=%h r0=%h cnt=%0d flt=%b",
                        n, rf_read_a, rf_read_b, r0, stack_count, stack_full, stack_empty, stack_fault,
                        m_regs[rf_read_addr_a], m_regs[rf_read_addr_b], m_regs[0], m_stk.size(), m_fault);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_write_read();
      test_push_pop();
      test_over_under();
      test_simultaneous();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
